led_pwm_dimmer: RTL and testbench

//  Brightness stage between led_kitt and the LED pads in led_driver_top: gates the logical 8-bit
//  LED pattern with a 16-level PWM. Level set by a debounced push-button (manual) or a triangle
//  "breathe" sequencer. Frame-aligned duty updates, polarity applied here, registered outputs.

---
 rtl/led_pwm_pkg.sv | 18 +
 rtl/btn_debounce.sv | 50 +++++
 rtl/led_pwm_dimmer.sv | 107 ++++++++++
 tb/tb_led_pwm_dimmer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the LED PWM dimmer: brightness level type,
// breathe sequencer states and the manual level stepping rule.
package led_pwm_pkg;

  typedef logic [3:0] level_t;

  typedef enum logic {RAMP_UP, RAMP_DOWN} breathe_state_e;

  localparam int     PWM_SLOTS = 16;
  localparam level_t LEVEL_RST = 4'd8;
  localparam level_t LEVEL_MAX = 4'd15;

  // Manual level never reaches 0, so a wrap from the top lands on 1
  function automatic level_t next_man_level(input level_t cur);
    return (cur == LEVEL_MAX) ? 4'd1 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a stability
// counter; emits a single-clock pulse on each debounced press.
module btn_debounce #(
  parameter int CLK_IN_MHZ  = 125,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int DB_CNT = CLK_IN_MHZ * 1000 * DEBOUNCE_MS;
  localparam int CNT_W  = $clog2(DB_CNT + 1);

  logic             sync_meta;
  logic             sync_q;
  logic             sync_prev;
  logic             db_state;
  logic [CNT_W-1:0] stable_cnt;

  // Any movement of the synced input restarts the stability window
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      sync_prev  <= 1'b0;
      db_state   <= 1'b0;
      stable_cnt <= '0;
      press_o    <= 1'b0;
    end else begin
      sync_meta <= btn_i;
      sync_q    <= sync_meta;
      sync_prev <= sync_q;
      press_o   <= 1'b0;
      if (sync_q != sync_prev) begin
        stable_cnt <= '0;
      end else if (sync_q == db_state) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DB_CNT - 1)) begin
        db_state   <= sync_q;
        stable_cnt <= '0;
        press_o    <= sync_q;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pwm_dimmer.sv
// Brightness stage for the LED pads: gates the logical pattern with a 16-level
// PWM whose duty comes from a debounced button or a triangle breathe sequencer.
module led_pwm_dimmer
  import led_pwm_pkg::*;
#(
  parameter int   CLK_IN_MHZ     = 125,
  parameter int   PWM_FREQ_KHZ   = 1,
  parameter int   DEBOUNCE_MS    = 10,
  parameter int   BREATHE_FRAMES = 32,
  parameter logic LED_POLARITY   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] led_i,
  input  logic       btn_i,
  input  logic       breathe_i,
  output logic [7:0] led_display_o,
  output logic [3:0] level_o
);

  localparam int SLOT_DIV = CLK_IN_MHZ * 1000 / (PWM_FREQ_KHZ * PWM_SLOTS);
  localparam int SLOT_W   = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
  localparam int FRAME_W  = (BREATHE_FRAMES > 1) ? $clog2(BREATHE_FRAMES) : 1;

  if (SLOT_DIV < 1) begin : g_slot_div_check
    $error("led_pwm_dimmer: clock too slow for requested PWM frame rate");
  end

  logic [SLOT_W-1:0]  slot_cnt;
  logic [3:0]         pwm_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  breathe_state_e     breathe_state;
  level_t             breathe_level;
  level_t             man_level;
  level_t             duty_q;
  level_t             sel_level;
  logic               press;
  logic               slot_tick;
  logic               frame_tick;
  logic               pwm_on;

  btn_debounce #(
    .CLK_IN_MHZ (CLK_IN_MHZ),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_btn_debounce (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_i),
    .press_o(press)
  );

  assign slot_tick  = (slot_cnt == SLOT_W'(SLOT_DIV - 1));
  assign frame_tick = slot_tick && (pwm_cnt == 4'(PWM_SLOTS - 1));
  assign pwm_on     = (pwm_cnt < duty_q);
  assign sel_level  = breathe_i ? breathe_level : man_level;
  assign level_o    = duty_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      slot_cnt <= slot_tick ? '0 : slot_cnt + SLOT_W'(1);
      if (slot_tick) pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  // Breathe runs free even in manual mode so switching sources is seamless
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt     <= '0;
      breathe_state <= RAMP_UP;
      breathe_level <= '0;
    end else if (frame_tick) begin
      if (frame_cnt == FRAME_W'(BREATHE_FRAMES - 1)) begin
        frame_cnt <= '0;
        case (breathe_state)
          RAMP_UP: begin
            breathe_level <= breathe_level + 4'd1;
            if (breathe_level == LEVEL_MAX - 4'd1) breathe_state <= RAMP_DOWN;
          end
          RAMP_DOWN: begin
            breathe_level <= breathe_level - 4'd1;
            if (breathe_level == 4'd1) breathe_state <= RAMP_UP;
          end
          default: breathe_state <= RAMP_UP;
        endcase
      end else begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  // Duty only moves at the frame boundary so a frame is never cut short
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      man_level     <= LEVEL_RST;
      duty_q        <= LEVEL_RST;
      led_display_o <= {8{~LED_POLARITY}};
    end else begin
      if (press) man_level <= next_man_level(man_level);
      if (frame_tick) duty_q <= sel_level;
      led_display_o <= ({8{pwm_on}} & led_i) ^ {8{~LED_POLARITY}};
    end
  end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Bench for led_pwm_dimmer: two instances (active-high and active-low pads)
// checked every clock against a frame-level model of duty and output.
module tb_led_pwm_dimmer;

  localparam int FRAME = 992;
  localparam int SLOT  = 62;

  typedef struct {
    logic       breathe;
    logic [3:0] exp_level;
    int         action;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, btn, breathe;
  logic [7:0] led;
  logic [7:0] out_a, out_b;
  logic [3:0] lvl_a, lvl_b;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         k [2];
  bit         valid [2];
  logic [3:0] duty_cur [2];
  logic [3:0] duty_prev [2];
  logic [3:0] man_model [2];
  bit         rand_led;
  vec_t       vecs [33];

  always #5 clk = ~clk;

  led_pwm_dimmer #(
    .CLK_IN_MHZ(1), .PWM_FREQ_KHZ(1), .DEBOUNCE_MS(1),
    .BREATHE_FRAMES(1), .LED_POLARITY(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a), .led_i(led), .btn_i(btn),
    .breathe_i(breathe), .led_display_o(out_a), .level_o(lvl_a)
  );

  led_pwm_dimmer #(
    .CLK_IN_MHZ(1), .PWM_FREQ_KHZ(1), .DEBOUNCE_MS(1),
    .BREATHE_FRAMES(1), .LED_POLARITY(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .led_i(led), .btn_i(btn),
    .breathe_i(breathe), .led_display_o(out_b), .level_o(lvl_b)
  );

  function automatic logic [3:0] breathe_seq(input int n);
    int m;
    m = n % 30;
    return (m <= 15) ? 4'(m) : 4'(30 - m);
  endfunction

  function automatic logic [3:0] man_next(input logic [3:0] cur);
    return (cur == 4'd15) ? 4'd1 : cur + 4'd1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge, advance the model, then drive led
  task automatic step();
    logic       r;
    logic [7:0] act_o, exp_o, mask;
    logic [3:0] act_l;
    int         s;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      r     = (d == 0) ? rst_a : rst_b;
      act_o = (d == 0) ? out_a : out_b;
      act_l = (d == 0) ? lvl_a : lvl_b;
      mask  = (d == 0) ? 8'h00 : 8'hFF;
      exp_o = mask;
      if (r) begin
        valid[d]     = 1'b1;
        k[d]         = 0;
        duty_cur[d]  = 4'd8;
        duty_prev[d] = 4'd8;
        man_model[d] = 4'd8;
      end else if (valid[d]) begin
        k[d]++;
        duty_prev[d] = duty_cur[d];
        if (k[d] % FRAME == 0)
          duty_cur[d] = breathe ? breathe_seq(k[d] / FRAME - 1) : man_model[d];
        s = k[d] - 1;
        exp_o = ((((s % FRAME) / SLOT) < int'(duty_prev[d])) ? led : 8'h00) ^ mask;
      end
      if (valid[d]) begin
        if (d == 0) begin
          checkOutput("out_a", {24'h0, act_o}, {24'h0, exp_o});
          checkOutput("level_a", {28'h0, act_l}, {28'h0, duty_cur[d]});
        end else begin
          checkOutput("out_b", {24'h0, act_o}, {24'h0, exp_o});
          checkOutput("level_b", {28'h0, act_l}, {28'h0, duty_cur[d]});
        end
      end
    end
    if (rand_led) led = 8'($urandom);
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic wait_offset(input int d, input int off);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((k[d] % FRAME != off) && (n < 2 * FRAME));
    if (k[d] % FRAME != off) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_offset: frame offset %0d required %0d", k[d] % FRAME, off);
    end
  endtask

  // Press lands early in a frame so acceptance falls well inside the next one
  task automatic press_button();
    wait_offset(0, 100);
    btn = 1'b1;
    step_n(1100);
    btn = 1'b0;
    for (int d = 0; d < 2; d++) man_model[d] = man_next(man_model[d]);
    step_n(1100);
  endtask

  task automatic applyStimulus(input vec_t v);
    wait_offset(1, 500);
    breathe = v.breathe;
    checkOutput("breathe_level_b", {28'h0, lvl_b}, {28'h0, v.exp_level});
    if (v.action == 1) begin
      step_n(100);
      btn = 1'b1;
    end else if (v.action == 2) begin
      checkOutput("pre_reset_level_a", {28'h0, lvl_a}, 32'd9);
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      checkOutput("reset_out_a", {24'h0, out_a}, 32'h00);
      checkOutput("reset_level_a", {28'h0, lvl_a}, 32'd8);
      step_n(300);
      btn = 1'b0;
      man_model[1] = man_next(man_model[1]);
    end
  endtask

  initial begin
    int lv [33] = '{8, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                    14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int hi, lo, top_on, lit, dark;
    for (int i = 0; i < 33; i++) begin
      vecs[i].breathe   = 1'b1;
      vecs[i].exp_level = 4'(lv[i]);
      vecs[i].action    = (i == 21) ? 1 : (i == 22) ? 2 : 0;
    end
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; btn = 1'b0; breathe = 1'b0;
    led = 8'hFF; rand_led = 1'b0;

    step_n(3);
    checkOutput("rst_out_a", {24'h0, out_a}, 32'h00);
    checkOutput("rst_out_b", {24'h0, out_b}, 32'hFF);
    checkOutput("rst_level_a", {28'h0, lvl_a}, 32'd8);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Level 8: exactly half of the first frame lit
    hi = 0; lo = 0;
    repeat (FRAME) begin
      step();
      if (out_a == 8'hFF) hi++;
      else if (out_a == 8'h00) lo++;
    end
    checkOutput("frame0_on_clocks", hi, 496);
    checkOutput("frame0_off_clocks", lo, 496);

    // Bouncing button never holds long enough to count
    rand_led = 1'b1;
    wait_offset(0, 100);
    for (int i = 0; i < 9; i++) begin
      btn = (i % 2 == 0);
      step_n(100);
    end
    btn = 1'b0;
    step_n(2000);
    checkOutput("bounce_level", {28'h0, lvl_a}, 32'd8);

    for (int p = 0; p < 7; p++) press_button();
    wait_offset(0, 500);
    checkOutput("level_after_7", {28'h0, lvl_a}, 32'd15);

    // Active-low pads at level 15 with only the low nibble lit
    rand_led = 1'b0;
    led = 8'h0F;
    wait_offset(1, 0);
    top_on = 0; lit = 0; dark = 0;
    repeat (FRAME) begin
      step();
      if (out_b[7:4] == 4'hF) top_on++;
      if (out_b[3:0] == 4'h0) lit++;
      else if (out_b[3:0] == 4'hF) dark++;
    end
    checkOutput("pol0_upper_high", top_on, FRAME);
    checkOutput("pol0_low_clocks", lit, 930);
    checkOutput("pol0_high_clocks", dark, 62);

    rand_led = 1'b1;
    press_button();
    wait_offset(0, 500);
    checkOutput("level_wrap", {28'h0, lvl_a}, 32'd1);

    // Breathe sequence from reset, with a mid-ramp reset on instance a
    breathe = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 33; i++) applyStimulus(vecs[i]);

    step_n(200);
    breathe = 1'b0;
    step_n(2500);
    checkOutput("final_level_a", {28'h0, lvl_a}, 32'd8);
    checkOutput("final_level_b", {28'h0, lvl_b}, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
